// File: rtl/sd_accum.sv
// sd_accum: synapse/dendrite accumulator. Each axon event sums the enabled
// lane weights and read-modify-writes the total into a double-buffered
// membrane-potential (Vm) store. On tik the accumulate and readout banks swap
// and the new accumulate bank is cleared by a hardware sweep.
module sd_accum #(
  parameter int NNW     = 12,
  parameter int VW      = 20,
  parameter int WW      = 16,
  parameter int WD      = 6,
  parameter int LAN_num = 2,
  parameter int SAT     = 1
) (
  input  logic                   clk_SD,
  input  logic                   rst_n,
  input  logic                   tik,
  input  logic                   axon_sd_vld,
  output logic                   axon_sd_rdy,
  input  logic [NNW-1:0]         axon_sd_vm_addr,
  input  logic [WD-1:0]          axon_sd_wgt_addr,
  input  logic [LAN_num-1:0]     axon_sd_lans,
  input  logic                   soma_sd_re,
  input  logic [NNW-1:0]         soma_sd_raddr,
  output logic signed [VW-1:0]   sd_soma_vm,
  output logic                   sd_soma_vld,
  input  logic                   config_sd_wgt_we,
  input  logic [LAN_num-1:0]     config_sd_wgt_lane,
  input  logic [WD-1:0]          config_sd_wgt_waddr,
  input  logic signed [WW-1:0]   config_sd_wgt_wdata,
  input  logic                   config_sd_vm_we,
  input  logic [NNW-1:0]         config_sd_vm_waddr,
  input  logic signed [VW-1:0]   config_sd_vm_wdata,
  output logic                   sd_busy,
  output logic [15:0]            sd_sat_cnt,
  output logic                   sd_tik_err
);

  localparam int DEPTH  = 1 << NNW;
  localparam int WDEPTH = 1 << WD;
  // Sum width: Vm plus one bit per doubling of lanes plus a carry bit.
  localparam int SW     = VW + $clog2(LAN_num) + 1;
  localparam logic signed [SW-1:0] VMAX = {{(SW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [SW-1:0] VMIN = {{(SW-VW+1){1'b1}}, {(VW-1){1'b0}}};

  typedef enum logic [1:0] {INIT, IDLE, DRAIN, CLEAR} state_t;

  // Sum of sign-extended weights of the enabled lanes.
  function automatic logic signed [SW-1:0] lane_sum(
    input logic [LAN_num-1:0]    lans,
    input logic [LAN_num*WW-1:0] wgts
  );
    logic signed [SW-1:0] acc;
    logic signed [WW-1:0] w;
    acc = '0;
    for (int l = 0; l < LAN_num; l++) begin
      w = wgts[l*WW +: WW];
      if (lans[l]) acc = acc + {{(SW-WW){w[WW-1]}}, w};
    end
    return acc;
  endfunction

  function automatic logic clamp_hit(input logic signed [SW-1:0] full);
    return (full > VMAX) || (full < VMIN);
  endfunction

  function automatic logic signed [VW-1:0] sat_vm(input logic signed [SW-1:0] full);
    if (full > VMAX) return VMAX[VW-1:0];
    if (full < VMIN) return VMIN[VW-1:0];
    return full[VW-1:0];
  endfunction

  // Storage: Vm bank b lives at {b, addr}; weights per lane.
  logic signed [VW-1:0] vm_mem  [2*DEPTH];
  logic signed [WW-1:0] wgt_mem [LAN_num][WDEPTH];

  state_t              state_q, state_d;
  logic                bank_sel;
  logic [NNW:0]        sweep_cnt;
  logic                sweep_last, drain_done;
  logic                accept, load_acc;

  logic                vld_p0, load_p0;
  logic [NNW-1:0]      addr_p0;
  logic [LAN_num-1:0]  lans_p0;
  logic signed [VW-1:0] ldata_p0, vm_rd_p0;
  logic [LAN_num*WW-1:0] wgt_rd_p0;

  logic                vld_p1;
  logic [NNW-1:0]      addr_p1;
  logic signed [VW-1:0] data_p1;

  logic signed [VW-1:0] vm_cur, vm_new;
  logic signed [SW-1:0] full_sum;
  logic                sat_hit;

  logic                mem_we;
  logic [NNW:0]        mem_waddr;
  logic signed [VW-1:0] mem_wdata;

  assign accept   = axon_sd_vld && axon_sd_rdy;
  assign load_acc = config_sd_vm_we && (state_q == IDLE);

  // FSM state register.
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // FSM next state, handshake/status outputs and Vm write-port steering.
  always_comb begin
    state_d     = state_q;
    axon_sd_rdy = 1'b0;
    sd_busy     = 1'b1;
    sd_tik_err  = 1'b0;
    drain_done  = 1'b0;
    sweep_last  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = {bank_sel, addr_p0};
    mem_wdata   = vm_new;
    case (state_q)
      INIT: begin
        sd_tik_err = tik;
        sweep_last = &sweep_cnt;
        mem_we     = 1'b1;
        mem_waddr  = sweep_cnt;
        mem_wdata  = '0;
        if (sweep_last) state_d = IDLE;
      end
      IDLE: begin
        sd_busy     = 1'b0;
        axon_sd_rdy = !config_sd_vm_we;
        mem_we      = vld_p0;
        if (tik) state_d = DRAIN;
      end
      DRAIN: begin
        sd_tik_err = tik;
        mem_we     = vld_p0;
        if (!vld_p0 && !vld_p1) begin
          drain_done = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        sd_tik_err = tik;
        sweep_last = &sweep_cnt[NNW-1:0];
        mem_we     = 1'b1;
        mem_waddr  = {bank_sel, sweep_cnt[NNW-1:0]};
        mem_wdata  = '0;
        if (sweep_last) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Bank select flips once the pipeline has drained; sweep address advances
  // during INIT (both banks) and CLEAR (new accumulate bank only).
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel  <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      if (drain_done) bank_sel <= ~bank_sel;
      if (state_q == INIT || state_q == CLEAR)
        sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
    end
  end

  // Weight banks: every selected lane takes the write; reads return old data.
  always_ff @(posedge clk_SD) begin
    for (int l = 0; l < LAN_num; l++) begin
      if (config_sd_wgt_we && config_sd_wgt_lane[l])
        wgt_mem[l][config_sd_wgt_waddr] <= config_sd_wgt_wdata;
      wgt_rd_p0[l*WW +: WW] <= wgt_mem[l][axon_sd_wgt_addr];
    end
  end

  // ---- S0: register the accepted operation and read the accumulate bank ----
  // Vm store single write port plus the S0 read of the accumulate bank.
  always_ff @(posedge clk_SD) begin
    if (mem_we) vm_mem[mem_waddr] <= mem_wdata;
    vm_rd_p0 <= vm_mem[{bank_sel, axon_sd_vm_addr}];
  end

  // S0 control: a config load takes the slot in place of an axon event.
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      load_p0 <= 1'b0;
    end else begin
      vld_p0  <= accept || load_acc;
      load_p0 <= load_acc;
    end
  end

  // S0 data.
  always_ff @(posedge clk_SD) begin
    addr_p0  <= load_acc ? config_sd_vm_waddr : axon_sd_vm_addr;
    lans_p0  <= axon_sd_lans;
    ldata_p0 <= config_sd_vm_wdata;
  end

  // ---- S1: forward the previous result, add the lane sum, clamp or wrap ----
  // The previous op's write lands on the same edge as this op's RAM read.
  always_comb begin
    vm_cur = vm_rd_p0;
    if (vld_p1 && (addr_p1 == addr_p0)) vm_cur = data_p1;
    full_sum = {{(SW-VW){vm_cur[VW-1]}}, vm_cur} + lane_sum(lans_p0, wgt_rd_p0);
    sat_hit  = 1'b0;
    vm_new   = full_sum[VW-1:0];
    if (load_p0) begin
      vm_new = ldata_p0;
    end else if (SAT != 0) begin
      sat_hit = clamp_hit(full_sum);
      vm_new  = sat_vm(full_sum);
    end
  end

  // ---- P1: last written result, kept for forwarding ----
  // Forwarding valid.
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // Forwarding address/data.
  always_ff @(posedge clk_SD) begin
    addr_p1 <= addr_p0;
    data_p1 <= vm_new;
  end

  // Saturation counter: sticky at full scale, restarted at each bank swap.
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n)                                         sd_sat_cnt <= '0;
    else if (drain_done)                                sd_sat_cnt <= '0;
    else if (vld_p0 && sat_hit && sd_sat_cnt != 16'hFFFF) sd_sat_cnt <= sd_sat_cnt + 16'd1;
  end

  // Soma readout: bank chosen by bank_sel at request time; data holds when idle.
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n) begin
      sd_soma_vld <= 1'b0;
      sd_soma_vm  <= '0;
    end else begin
      sd_soma_vld <= soma_sd_re;
      if (soma_sd_re) sd_soma_vm <= vm_mem[{~bank_sel, soma_sd_raddr}];
    end
  end

endmodule

// File: tb/tb_sd_accum.sv
// Bench for sd_accum: two instances (saturating and wrap-around) share all
// inputs and are checked against a bank-level model of the Vm store.
module tb_sd_accum;

  logic        clk = 1'b0;
  logic        rst_n, tik, axon_vld, soma_re;
  logic [3:0]  axon_vm_addr, soma_raddr, cfg_vm_waddr;
  logic [5:0]  axon_wgt_addr, cfg_wgt_waddr;
  logic [1:0]  axon_lans, cfg_wgt_lane;
  logic        cfg_wgt_we, cfg_vm_we;
  logic [15:0] cfg_wgt_wdata;
  logic [19:0] cfg_vm_wdata;

  logic        rdy_s, rdy_w, svld_s, svld_w, busy_s, busy_w, terr_s, terr_w;
  logic [19:0] vm_s, vm_w;
  logic [15:0] sat_s, sat_w;

  int checks = 0;
  int failures = 0;

  // Model: accumulate and readout banks per instance, weights, sat count.
  longint acc_s[16], acc_w[16], out_s[16], out_w[16];
  longint wgt[2][64];
  int     msat_s;

  always #5 clk = ~clk;

  sd_accum #(.NNW(4), .VW(20), .WW(16), .WD(6), .LAN_num(2), .SAT(1)) dut_s (
    .clk_SD(clk), .rst_n(rst_n), .tik(tik),
    .axon_sd_vld(axon_vld), .axon_sd_rdy(rdy_s), .axon_sd_vm_addr(axon_vm_addr),
    .axon_sd_wgt_addr(axon_wgt_addr), .axon_sd_lans(axon_lans),
    .soma_sd_re(soma_re), .soma_sd_raddr(soma_raddr), .sd_soma_vm(vm_s), .sd_soma_vld(svld_s),
    .config_sd_wgt_we(cfg_wgt_we), .config_sd_wgt_lane(cfg_wgt_lane),
    .config_sd_wgt_waddr(cfg_wgt_waddr), .config_sd_wgt_wdata(cfg_wgt_wdata),
    .config_sd_vm_we(cfg_vm_we), .config_sd_vm_waddr(cfg_vm_waddr), .config_sd_vm_wdata(cfg_vm_wdata),
    .sd_busy(busy_s), .sd_sat_cnt(sat_s), .sd_tik_err(terr_s));

  sd_accum #(.NNW(4), .VW(20), .WW(16), .WD(6), .LAN_num(2), .SAT(0)) dut_w (
    .clk_SD(clk), .rst_n(rst_n), .tik(tik),
    .axon_sd_vld(axon_vld), .axon_sd_rdy(rdy_w), .axon_sd_vm_addr(axon_vm_addr),
    .axon_sd_wgt_addr(axon_wgt_addr), .axon_sd_lans(axon_lans),
    .soma_sd_re(soma_re), .soma_sd_raddr(soma_raddr), .sd_soma_vm(vm_w), .sd_soma_vld(svld_w),
    .config_sd_wgt_we(cfg_wgt_we), .config_sd_wgt_lane(cfg_wgt_lane),
    .config_sd_wgt_waddr(cfg_wgt_waddr), .config_sd_wgt_wdata(cfg_wgt_wdata),
    .config_sd_vm_we(cfg_vm_we), .config_sd_vm_waddr(cfg_vm_waddr), .config_sd_vm_wdata(cfg_vm_wdata),
    .sd_busy(busy_w), .sd_sat_cnt(sat_w), .sd_tik_err(terr_w));

  // ---------------- reference model ----------------
  function automatic longint wrap20(input longint v);
    longint t;
    t = v & 64'hFFFFF;
    if (t >= 524288) t = t - 1048576;
    return t;
  endfunction

  function automatic void model_zero();
    for (int a = 0; a < 16; a++) begin
      acc_s[a] = 0; acc_w[a] = 0; out_s[a] = 0; out_w[a] = 0;
    end
    msat_s = 0;
  endfunction

  function automatic void model_event(input int a, input int row, input int lans);
    longint sum, t;
    sum = 0;
    for (int l = 0; l < 2; l++) if (lans[l]) sum += wgt[l][row];
    t = acc_s[a] + sum;
    if (t > 524287) begin
      t = 524287;
      if (msat_s < 65535) msat_s++;
    end else if (t < -524288) begin
      t = -524288;
      if (msat_s < 65535) msat_s++;
    end
    acc_s[a] = t;
    acc_w[a] = wrap20(acc_w[a] + sum);
  endfunction

  function automatic void model_tik();
    for (int a = 0; a < 16; a++) begin
      out_s[a] = acc_s[a]; out_w[a] = acc_w[a];
      acc_s[a] = 0;        acc_w[a] = 0;
    end
    msat_s = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wgt_write(input int mask, input int row, input longint v);
    cfg_wgt_we = 1'b1; cfg_wgt_lane = mask[1:0]; cfg_wgt_waddr = row[5:0]; cfg_wgt_wdata = v[15:0];
    @(posedge clk); #1;
    cfg_wgt_we = 1'b0;
    for (int l = 0; l < 2; l++) if (mask[l]) wgt[l][row] = v;
  endtask

  task automatic cfg_load(input int a, input longint v);
    cfg_vm_we = 1'b1; cfg_vm_waddr = a[3:0]; cfg_vm_wdata = v[19:0];
    @(posedge clk); #1;
    cfg_vm_we = 1'b0;
    acc_s[a] = v; acc_w[a] = v;
  endtask

  task automatic send_event(input int a, input int row, input int lans);
    bit ok;
    ok = 1'b0;
    axon_vld = 1'b1; axon_vm_addr = a[3:0]; axon_wgt_addr = row[5:0]; axon_lans = lans[1:0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy_s && rdy_w) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL event_accept addr=%0d rdy=%b required=1", a, rdy_s); end
    else begin @(posedge clk); #1; model_event(a, row, lans); end
    axon_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_s) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL idle_timeout busy=%b required=0", busy_s); end
    @(posedge clk); #1;
  endtask

  task automatic do_tik();
    tik = 1'b1;
    @(negedge clk);
    checks++;
    if (terr_s !== 1'b0) begin failures++; $display("FAIL tik_err_idle got=%b required=0", terr_s); end
    @(posedge clk); #1;
    tik = 1'b0;
    model_tik();
    wait_idle();
  endtask

  task automatic check_read(input int a, input longint es, input longint ew);
    logic [19:0] xs, xw;
    xs = es[19:0]; xw = ew[19:0];
    soma_re = 1'b1; soma_raddr = a[3:0];
    @(posedge clk); #1;
    soma_re = 1'b0;
    @(negedge clk);
    checks++;
    if (svld_s !== 1'b1 || svld_w !== 1'b1) begin
      failures++; $display("FAIL soma_vld addr=%0d got=%b/%b required=1", a, svld_s, svld_w);
    end
    checks++;
    if (vm_s !== xs) begin
      failures++; $display("FAIL read_sat addr=%0d got=%0d required=%0d", a, $signed(vm_s), $signed(xs));
    end
    checks++;
    if (vm_w !== xw) begin
      failures++; $display("FAIL read_wrap addr=%0d got=%0d required=%0d", a, $signed(vm_w), $signed(xw));
    end
    @(posedge clk); #1;
  endtask

  task automatic count_init_busy(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_s) break;
      n++;
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL %s_busy_cycles got=%0d required=32", tag, n); end
    checks++;
    if (busy_w !== 1'b0 || rdy_s !== 1'b1 || rdy_w !== 1'b1) begin
      failures++; $display("FAIL %s_ready got busy=%b rdy=%b required busy=0 rdy=1", tag, busy_w, rdy_s);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; tik = 1'b0; axon_vld = 1'b0; soma_re = 1'b0;
    axon_vm_addr = '0; axon_wgt_addr = '0; axon_lans = '0; soma_raddr = '0;
    cfg_wgt_we = 1'b0; cfg_wgt_lane = '0; cfg_wgt_waddr = '0; cfg_wgt_wdata = '0;
    cfg_vm_we = 1'b0; cfg_vm_waddr = '0; cfg_vm_wdata = '0;
    model_zero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0 || rdy_w !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b required=0", rdy_s); end
    checks++;
    if (svld_s !== 1'b0 || svld_w !== 1'b0) begin failures++; $display("FAIL reset_soma_vld got=%b required=0", svld_s); end
    checks++;
    if (vm_s !== 20'd0 || vm_w !== 20'd0) begin failures++; $display("FAIL reset_soma_vm got=%0d required=0", vm_s); end
    checks++;
    if (sat_s !== 16'd0 || sat_w !== 16'd0) begin failures++; $display("FAIL reset_sat_cnt got=%0d required=0", sat_s); end
    checks++;
    if (terr_s !== 1'b0 || terr_w !== 1'b0) begin failures++; $display("FAIL reset_tik_err got=%b required=0", terr_s); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_init_busy("init");
    do_tik();
    check_read(0, 0, 0);
    check_read(5, 0, 0);
    check_read(15, 0, 0);
  endtask

  task automatic test_accumulate();
    wgt_write(2'b01, 3, 100);
    wgt_write(2'b10, 3, -30);
    send_event(5, 3, 3);
    send_event(5, 3, 3);
    send_event(5, 3, 3);
    do_tik();
    check_read(5, 210, 210);
  endtask

  task automatic test_saturation();
    wgt_write(2'b01, 10, 100);
    cfg_load(2, 524280);
    send_event(2, 10, 1);
    idle(3);
    checks++;
    if (sat_s !== 16'd1) begin failures++; $display("FAIL sat_cnt_sat got=%0d required=1", sat_s); end
    checks++;
    if (sat_w !== 16'd0) begin failures++; $display("FAIL sat_cnt_wrap got=%0d required=0", sat_w); end
    do_tik();
    checks++;
    if (sat_s !== 16'd0) begin failures++; $display("FAIL sat_cnt_after_swap got=%0d required=0", sat_s); end
    check_read(2, 524287, -524196);
  endtask

  task automatic test_forwarding();
    wgt_write(2'b01, 20, 1);
    wgt_write(2'b01, 21, 2);
    wgt_write(2'b01, 22, 4);
    send_event(7, 20, 1);
    send_event(7, 21, 1);
    send_event(8, 22, 1);
    do_tik();
    check_read(7, 3, 3);
    check_read(8, 4, 4);
  endtask

  task automatic test_tik_in_flight();
    int n;
    bit rdy_bad, err_seen;
    wgt_write(2'b01, 30, 5);
    wgt_write(2'b10, 30, 7);
    axon_vld = 1'b1; axon_vm_addr = 4'd10; axon_wgt_addr = 6'd30; axon_lans = 2'b11;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b1) begin failures++; $display("FAIL inflight_accept0 got=%b required=1", rdy_s); end
    @(posedge clk); #1;
    axon_vm_addr = 4'd11; tik = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b1 || terr_s !== 1'b0) begin
      failures++; $display("FAIL inflight_accept1 got rdy=%b err=%b required rdy=1 err=0", rdy_s, terr_s);
    end
    @(posedge clk); #1;
    axon_vld = 1'b0; tik = 1'b0;
    model_event(10, 30, 3); model_event(11, 30, 3); model_tik();
    n = 0; rdy_bad = 1'b0; err_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tik = (c == 8); cfg_vm_we = (c == 8); cfg_vm_waddr = 4'd9; cfg_vm_wdata = 20'd777;
      @(negedge clk);
      if (!busy_s) break;
      if (c == 8) err_seen = terr_s && terr_w;
      if (rdy_s) rdy_bad = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    tik = 1'b0; cfg_vm_we = 1'b0;
    checks++;
    if (!err_seen) begin failures++; $display("FAIL tik_err_clear got=0 required=1"); end
    checks++;
    if (rdy_bad) begin failures++; $display("FAIL rdy_while_busy got=1 required=0"); end
    checks++;
    if (n < 17 || n > 24) begin failures++; $display("FAIL swap_busy_cycles got=%0d required=17..24", n); end
    checks++;
    if (rdy_s !== 1'b1) begin failures++; $display("FAIL rdy_after_clear got=%b required=1", rdy_s); end
    @(posedge clk); #1;
    check_read(10, 12, 12);
    check_read(11, 12, 12);
    do_tik();
    check_read(9, 0, 0);
    check_read(10, 0, 0);
  endtask

  task automatic test_config_priority();
    wgt_write(2'b10, 40, 123);
    cfg_vm_we = 1'b1; cfg_vm_waddr = 4'd12; cfg_vm_wdata = 20'hFEC78;  // -5000
    axon_vld = 1'b1; axon_vm_addr = 4'd12; axon_wgt_addr = 6'd40; axon_lans = 2'b10;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0) begin failures++; $display("FAIL cfg_blocks_event got=%b required=0", rdy_s); end
    @(posedge clk); #1;
    cfg_vm_we = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b1) begin failures++; $display("FAIL held_event_accept got=%b required=1", rdy_s); end
    @(posedge clk); #1;
    axon_vld = 1'b0;
    acc_s[12] = -5000; acc_w[12] = -5000;
    model_event(12, 40, 2);
    do_tik();
    check_read(12, -4877, -4877);
  endtask

  task automatic test_random();
    for (int r = 48; r < 56; r++) begin
      wgt_write(2'b01, r, longint'($urandom_range(16000, 32767)));
      wgt_write(2'b10, r, longint'($urandom_range(0, 65535)) - 32768);
    end
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 7) == 0)
        cfg_load($urandom_range(0, 2), longint'($urandom_range(0, 1048575)) - 524288);
      else
        send_event($urandom_range(0, 2), $urandom_range(48, 55), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    checks++;
    if (sat_s !== 16'(msat_s)) begin failures++; $display("FAIL rand_sat_cnt got=%0d required=%0d", sat_s, msat_s); end
    checks++;
    if (sat_w !== 16'd0) begin failures++; $display("FAIL rand_sat_cnt_wrap got=%0d required=0", sat_w); end
    do_tik();
    for (int a = 0; a < 16; a++) check_read(a, out_s[a], out_w[a]);
  endtask

  task automatic test_reset_midop();
    send_event(1, 48, 3);
    axon_vld = 1'b1; axon_vm_addr = 4'd1; axon_wgt_addr = 6'd48; axon_lans = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b0; axon_vld = 1'b0;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_init_busy("midop_reset");
    do_tik();
    check_read(1, 0, 0);
    check_read(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturation();
    test_forwarding();
    test_tik_in_flight();
    test_config_priority();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
